fix_recursion_scheduler: RTL and testbench
==========================================

Name: fix_recursion_scheduler

Overview:
- Time-multiplexes one shared complex fixed-point recursion datapath, prod = prev*factor + in, across N_CH independent first-order recursion channels.
- Holds the per-channel state (prev), factor and reset value, and issues one operation per cycle to the external pipelined datapath.
- Tracks in-flight channels to stall read-after-write hazards, and writes results back as they return.
- Sits between the filter's sample front end and the shared CFixPU MULT/ADD pair.

Parameters:
- N_CH, 4, number of recursion channels.
- n_int, 8, integer bits of the fixed-point word. Word width W = n_int+n_mant+1, signed.
- n_mant, 23, fractional bits.
- DP_LAT, 2, datapath latency in cycles from operand issue to result.
- CH_W, $clog2(N_CH) (minimum 1), channel index width.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  write factor/reset value for cfg_ch.
- cfg_ch  in  CH_W  configuration channel index.
- cfg_factR, cfg_factI  in  W  recursion factor.
- cfg_rstR, cfg_rstI  in  W  reset value loaded into state on restart.
- restart  in  1  one-cycle pulse: drain, then reload all states from reset values.
- in_valid  in  1  sample offered.
- in_ready  out  1  sample accepted this cycle when in_valid && in_ready.
- in_ch  in  CH_W  target channel of the sample.
- inR, inI  in  W  sample value.
- dp_issue  out  1  operands valid this cycle.
- dp_aR, dp_aI  out  W  prev state operand.
- dp_bR, dp_bI  out  W  factor operand.
- dp_cR, dp_cI  out  W  input operand.
- dp_sumR, dp_sumI  in  W  datapath result, valid exactly DP_LAT cycles after dp_issue.
- out_valid  out  1  result produced (no backpressure).
- out_ch  out  CH_W  channel of the result.
- outR, outI  out  W  result value (the new state).
- busy  out  1  ops in flight or FSM not in RUN.

Behaviour:
- Reset (rst high, asynchronous):
  - all state, factor and reset-value registers = 0;
  - FSM = RUN; scoreboard and tag pipe cleared;
  - in_ready, dp_issue, out_valid, busy = 0; out_ch, outR, outI = 0.
  - Reset mid-operation discards all in-flight results.
- Issue:
  - Issue is combinational on handshake: dp_issue = in_valid && in_ready.
  - dp_a = state[in_ch], dp_b = factor[in_ch], dp_c = in.
  - Factor is sampled at issue. A cfg write in the same cycle to the same channel affects only later issues.
- Tag pipe:
  - A DP_LAT-deep shift register carries {valid, ch} for each issue.
  - On tag exit: state[ch] <= dp_sum, out_valid = 1, out_ch = ch, out = dp_sum (registered, 1 cycle after dp_sum is valid).
  - Total latency from accept to out_valid = DP_LAT+1.
- Scoreboard (one pend bit per channel):
  - Set on issue, cleared on return.
  - in_ready = (FSM == RUN) && (!pend[in_ch] || returning_ch == in_ch).
- Bypass:
  - When a channel returns and is issued in the same cycle, dp_a = dp_sum (forwarded).
  - pend stays set for that channel.
- Throughput: distinct channels can be issued on every cycle. A single channel sustains one sample per DP_LAT cycles.
- FSM:
  - RUN -> DRAIN on restart.
  - DRAIN: in_ready = 0; in-flight results still return and emit out_valid.
  - DRAIN -> LOAD when the scoreboard is empty (immediately if already empty).
  - LOAD, one cycle: state[c] <= rst value[c] for all c. A cfg write in that same cycle loads the new reset value.
  - LOAD -> RUN.
  - restart pulses while in DRAIN or LOAD are ignored.
- Arithmetic: none internally. All words are W-bit signed two's complement, passed unmodified.
- Config writes are accepted in every FSM state.
- Out-of-range cfg_ch or in_ch (>= N_CH): the write is ignored and the sample is never accepted (in_ready = 0).

Test Plan:
- Single-channel recursion.
  - Stimulus: DP_LAT=2, reference datapath model; ch0 factor 0x00400000 (0.5), reset value 0, restart; then inR = 0x00800000 (1.0) offered continuously.
  - Required: in_ready high only every 2nd cycle; outR = 0x00800000, 0x00C00000, 0x00E00000; outI = 0.
- Interleaved channels.
  - Stimulus: 4 channels issued round-robin, one per cycle.
  - Required: in_ready is never low; out_ch sequence is 0,1,2,3 starting 3 cycles after the first accept.
- Bypass.
  - Stimulus: ch2 with factor (0,1.0) i.e. 0x0/0x00800000, state 1.0+0j, input 0; issued back-to-back as allowed.
  - Required: outputs rotate 0+1j, -1+0j, 0-1j; the forwarded dp_a matches dp_sum.
- Restart mid-stream.
  - Stimulus: restart while 2 ops are in flight.
  - Required: both results still emitted; in_ready low until LOAD completes; next ch0 result = reset value*factor + in.
- Config race.
  - Stimulus: cfg_we for ch1 with a new factor in the same cycle ch1 is issued.
  - Required: that op uses the old factor; the next op uses the new factor.
- Async reset.
  - Stimulus: rst asserted between clock edges with ops in flight.
  - Required: all outputs are 0 immediately; no out_valid after release.

Source files
------------

// File: rtl/fix_recursion_scheduler.sv
// Scheduler for N_CH first-order complex recursions sharing one pipelined
// multiply-add datapath (prod = prev*factor + in). Holds per-channel state,
// factor and reset value, stalls read-after-write hazards with a pend bit per
// channel, forwards returning results to a same-cycle reissue, and handles a
// drain/reload restart sequence.
module fix_recursion_scheduler #(
  parameter int N_CH   = 4,
  parameter int n_int  = 8,
  parameter int n_mant = 23,
  parameter int DP_LAT = 2,
  parameter int W      = n_int + n_mant + 1,
  parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [W-1:0]    cfg_factR,
  input  logic [W-1:0]    cfg_factI,
  input  logic [W-1:0]    cfg_rstR,
  input  logic [W-1:0]    cfg_rstI,
  input  logic            restart,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH_W-1:0] in_ch,
  input  logic [W-1:0]    inR,
  input  logic [W-1:0]    inI,
  output logic            dp_issue,
  output logic [W-1:0]    dp_aR,
  output logic [W-1:0]    dp_aI,
  output logic [W-1:0]    dp_bR,
  output logic [W-1:0]    dp_bI,
  output logic [W-1:0]    dp_cR,
  output logic [W-1:0]    dp_cI,
  input  logic [W-1:0]    dp_sumR,
  input  logic [W-1:0]    dp_sumI,
  output logic            out_valid,
  output logic [CH_W-1:0] out_ch,
  output logic [W-1:0]    outR,
  output logic [W-1:0]    outI,
  output logic            busy
);

  localparam logic [CH_W:0] NCH_L = (CH_W + 1)'(N_CH);

  typedef enum logic [1:0] {RUN, DRAIN, LOAD} fsm_e;

  fsm_e            fsm_q, fsm_d;
  logic [W-1:0]    stR_q [N_CH];
  logic [W-1:0]    stI_q [N_CH];
  logic [W-1:0]    fR_q  [N_CH];
  logic [W-1:0]    fI_q  [N_CH];
  logic [W-1:0]    rR_q  [N_CH];
  logic [W-1:0]    rI_q  [N_CH];
  logic [N_CH-1:0] pend_q, pend_d;
  logic [DP_LAT-1:0] tv_q;
  logic [CH_W-1:0] tch_q [DP_LAT];
  logic            out_valid_q;
  logic [CH_W-1:0] out_ch_q;
  logic [W-1:0]    outR_q, outI_q;

  logic            in_ok, cfg_ok, ret_v, byp, issue;
  logic [CH_W-1:0] ret_ch;

  assign in_ok  = {1'b0, in_ch} < NCH_L;
  assign cfg_ok = {1'b0, cfg_ch} < NCH_L;
  assign ret_v  = tv_q[DP_LAT-1];
  assign ret_ch = tch_q[DP_LAT-1];
  assign byp    = ret_v && (ret_ch == in_ch);

  // Handshake and operand selection; a returning result is forwarded to a
  // same-cycle reissue of that channel instead of the not-yet-written state.
  always_comb begin
    in_ready = 1'b0;
    if (!rst && (fsm_q == RUN) && in_ok)
      in_ready = !pend_q[in_ch] || byp;
    issue    = in_valid && in_ready;
    dp_issue = issue;
    dp_aR    = byp ? dp_sumR : stR_q[in_ch];
    dp_aI    = byp ? dp_sumI : stI_q[in_ch];
    dp_bR    = fR_q[in_ch];
    dp_bI    = fI_q[in_ch];
    dp_cR    = inR;
    dp_cI    = inI;
  end

  // Scoreboard next state: return clears, issue sets (issue wins on bypass).
  always_comb begin
    pend_d = pend_q;
    if (ret_v) pend_d[ret_ch] = 1'b0;
    if (issue) pend_d[in_ch]  = 1'b1;
  end

  // Restart sequencing: stop accepting, wait for the scoreboard to empty,
  // reload every channel for one cycle, resume.
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      RUN:     if (restart) fsm_d = DRAIN;
      DRAIN:   if (pend_q == '0) fsm_d = LOAD;
      LOAD:    fsm_d = RUN;
      default: fsm_d = RUN;
    endcase
  end

  // FSM and scoreboard registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q  <= RUN;
      pend_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      pend_q <= pend_d;
    end
  end

  // Tag pipe: {valid, ch} aligned with the datapath latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tv_q <= '0;
      for (int unsigned k = 0; k < DP_LAT; k++) tch_q[k] <= '0;
    end else begin
      tv_q[0]  <= issue;
      tch_q[0] <= in_ch;
      for (int unsigned k = 1; k < DP_LAT; k++) begin
        tv_q[k]  <= tv_q[k-1];
        tch_q[k] <= tch_q[k-1];
      end
    end
  end

  // Per-channel factor and reset-value configuration, writable in any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        fR_q[c] <= '0;
        fI_q[c] <= '0;
        rR_q[c] <= '0;
        rI_q[c] <= '0;
      end
    end else if (cfg_we && cfg_ok) begin
      fR_q[cfg_ch] <= cfg_factR;
      fI_q[cfg_ch] <= cfg_factI;
      rR_q[cfg_ch] <= cfg_rstR;
      rI_q[cfg_ch] <= cfg_rstI;
    end
  end

  // Channel state: reload from reset values in LOAD (a same-cycle cfg write
  // takes effect directly), otherwise write back returning results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        stR_q[c] <= '0;
        stI_q[c] <= '0;
      end
    end else if (fsm_q == LOAD) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (cfg_we && cfg_ok && (cfg_ch == CH_W'(c))) begin
          stR_q[c] <= cfg_rstR;
          stI_q[c] <= cfg_rstI;
        end else begin
          stR_q[c] <= rR_q[c];
          stI_q[c] <= rI_q[c];
        end
      end
    end else if (ret_v) begin
      stR_q[ret_ch] <= dp_sumR;
      stI_q[ret_ch] <= dp_sumI;
    end
  end

  // Registered result output; value holds between results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      outR_q      <= '0;
      outI_q      <= '0;
    end else begin
      out_valid_q <= ret_v;
      if (ret_v) begin
        out_ch_q <= ret_ch;
        outR_q   <= dp_sumR;
        outI_q   <= dp_sumI;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign outR      = outR_q;
  assign outI      = outI_q;
  assign busy      = (pend_q != '0) || (fsm_q != RUN);

endmodule

// File: tb/tb_fix_recursion_scheduler.sv
// Bench for fix_recursion_scheduler: reference complex MAC datapath, a
// per-channel recursion model and an expected-result queue popped on out_valid.
module tb_fix_recursion_scheduler;

  localparam int N_CH   = 4;
  localparam int n_int  = 8;
  localparam int n_mant = 23;
  localparam int DP_LAT = 2;
  localparam int W      = n_int + n_mant + 1;
  localparam int CH_W   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_we, restart, in_valid, in_ready, dp_issue, out_valid, busy;
  logic [CH_W-1:0] cfg_ch, in_ch, out_ch;
  logic [W-1:0]    cfg_factR, cfg_factI, cfg_rstR, cfg_rstI, inR, inI;
  logic [W-1:0]    dp_aR, dp_aI, dp_bR, dp_bI, dp_cR, dp_cI, dp_sumR, dp_sumI;
  logic [W-1:0]    outR, outI;

  fix_recursion_scheduler #(
    .N_CH(N_CH), .n_int(n_int), .n_mant(n_mant), .DP_LAT(DP_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_factR(cfg_factR), .cfg_factI(cfg_factI),
    .cfg_rstR(cfg_rstR), .cfg_rstI(cfg_rstI),
    .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .inR(inR), .inI(inI),
    .dp_issue(dp_issue),
    .dp_aR(dp_aR), .dp_aI(dp_aI), .dp_bR(dp_bR), .dp_bI(dp_bI),
    .dp_cR(dp_cR), .dp_cI(dp_cI),
    .dp_sumR(dp_sumR), .dp_sumI(dp_sumI),
    .out_valid(out_valid), .out_ch(out_ch), .outR(outR), .outI(outI),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Fixed-point complex a*b + c, product rescaled by n_mant fractional bits.
  function automatic logic [2*W-1:0] cmac(input logic [W-1:0] aR, aI, bR, bI, cR, cI);
    logic signed [2*W+1:0] pR, pI;
    logic [W-1:0] r, i;
    pR = $signed(aR) * $signed(bR) - $signed(aI) * $signed(bI);
    pI = $signed(aR) * $signed(bI) + $signed(aI) * $signed(bR);
    r = W'(pR >>> n_mant) + cR;
    i = W'(pI >>> n_mant) + cI;
    return {r, i};
  endfunction

  // Reference pipelined datapath: result DP_LAT cycles after issue.
  logic [2*W-1:0] dpp [DP_LAT];
  always @(posedge clk) begin
    dpp[0] <= cmac(dp_aR, dp_aI, dp_bR, dp_bI, dp_cR, dp_cI);
    for (int k = 1; k < DP_LAT; k++) dpp[k] <= dpp[k-1];
  end
  assign {dp_sumR, dp_sumI} = dpp[DP_LAT-1];

  // Model of channel state, factors and reset values.
  logic [W-1:0] mR [N_CH], mI [N_CH], mfR [N_CH], mfI [N_CH], mrR [N_CH], mrI [N_CH];

  typedef struct {
    int           ch;
    logic [W-1:0] r;
    logic [W-1:0] i;
    int           cyc;
  } exp_t;
  exp_t q[$];

  // Result monitor.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_ch", out_ch, e.ch);
        check("outR", outR, e.r);
        check("outI", outI, e.i);
        check("out_latency", cyc - e.cyc, DP_LAT + 1);
      end
    end
  end

  task automatic model_clear();
    for (int c = 0; c < N_CH; c++) begin
      mR[c] = '0; mI[c] = '0; mfR[c] = '0; mfI[c] = '0; mrR[c] = '0; mrI[c] = '0;
    end
  endtask

  task automatic do_cfg(input int ch, input logic [W-1:0] fr, fi, rr, ri);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch);
    cfg_factR = fr; cfg_factI = fi; cfg_rstR = rr; cfg_rstI = ri;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    mfR[ch] = fr; mfI[ch] = fi; mrR[ch] = rr; mrI[ch] = ri;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      mR[c] = mrR[c]; mI[c] = mrI[c];
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    check("idle", busy, 0);
  endtask

  // Offer one sample until accepted; optionally a cfg write (fields preset)
  // rides in the first offered cycle.
  task automatic send(input int ch, input logic [W-1:0] r, i, input bit cfg_too, output int stalls);
    bit acc;
    logic [2*W-1:0] e2;
    exp_t e;
    acc = 1'b0; stalls = 0;
    in_valid = 1'b1; in_ch = CH_W'(ch); inR = r; inI = i;
    cfg_we = cfg_too;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        check("dp_issue", dp_issue, 1);
        check("dp_aR", dp_aR, mR[ch]);
        check("dp_aI", dp_aI, mI[ch]);
        check("dp_bR", dp_bR, mfR[ch]);
        check("dp_bI", dp_bI, mfI[ch]);
        e2 = cmac(mR[ch], mI[ch], mfR[ch], mfI[ch], r, i);
        {mR[ch], mI[ch]} = e2;
        e.ch = ch; e.r = e2[2*W-1:W]; e.i = e2[W-1:0]; e.cyc = cyc;
        q.push_back(e);
        acc = 1'b1;
      end
      @(posedge clk); #1;
      if (cfg_we) begin
        cfg_we = 1'b0;
        mfR[cfg_ch] = cfg_factR; mfI[cfg_ch] = cfg_factI;
        mrR[cfg_ch] = cfg_rstR;  mrI[cfg_ch] = cfg_rstI;
      end
      if (acc) break;
      stalls++;
    end
    in_valid = 1'b0;
    check("accepted", acc, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int st;
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; restart = 1'b0;
    cfg_factR = '0; cfg_factI = '0; cfg_rstR = '0; cfg_rstI = '0;
    in_valid = 1'b1; in_ch = '0; inR = '0; inI = '0;
    model_clear();
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_dp_issue", dp_issue, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out", {out_ch, outR, outI}, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single-channel recursion: 0.5 factor, 1.0 input, one accept per 2 cycles.
    do_cfg(0, 32'h0040_0000, '0, '0, '0);
    do_cfg(2, '0, 32'h0080_0000, 32'h0080_0000, '0);
    do_restart();
    wait_idle();
    for (int k = 0; k < 3; k++) begin
      send(0, 32'h0080_0000, '0, 1'b0, st);
      check("t1_stalls", st, (k == 0) ? 0 : 1);
    end
    wait_idle();

    // Bypass: ch2 rotates by j each op, reissue forwarded from dp_sum.
    for (int k = 0; k < 3; k++) begin
      send(2, '0, '0, 1'b0, st);
      check("byp_stalls", st, (k == 0) ? 0 : 1);
    end
    wait_idle();

    // Interleaved round-robin: never stalls.
    do_cfg(1, 32'h0040_0000, 32'h0020_0000, '0, '0);
    do_cfg(3, 32'hFFC0_0000, '0, '0, '0);
    for (int k = 0; k < 8; k++) begin
      send(k % N_CH, W'(32'h0010_0000 * (k + 1)), W'(32'h0008_0000 * k), 1'b0, st);
      check("rr_stalls", st, 0);
    end
    wait_idle();

    // Config race: same-cycle factor write to ch1 affects only the next op.
    cfg_ch = 2'd1; cfg_factR = 32'h0100_0000; cfg_factI = '0; cfg_rstR = '0; cfg_rstI = '0;
    send(1, 32'h0080_0000, '0, 1'b1, st);
    check("race_stalls", st, 0);
    send(1, 32'h0080_0000, '0, 1'b0, st);
    wait_idle();

    // Restart with two ops in flight; stalls through DRAIN/LOAD.
    do_cfg(0, 32'h0040_0000, '0, 32'h0020_0000, 32'h0010_0000);
    send(0, 32'h0080_0000, '0, 1'b0, st);
    send(1, 32'h0080_0000, '0, 1'b0, st);
    do_restart();
    send(0, 32'h0080_0000, '0, 1'b0, st);
    check("restart_stalls", st, 3);
    wait_idle();

    // Asynchronous reset between edges with ops in flight.
    send(0, 32'h0080_0000, '0, 1'b0, st);
    send(1, 32'h0080_0000, '0, 1'b0, st);
    @(posedge clk);
    in_valid = 1'b1; in_ch = 2'd3;
    #3;
    rst = 1'b1;
    q.delete();
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out", {out_ch, outR, outI}, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_dp_issue", dp_issue, 0);
    model_clear();
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    send(0, 32'h0000_0100, 32'h0000_0200, 1'b0, st);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
